// File: rtl/alert_pkg.sv
// Shared types and default constants for the alert qualification path
// feeding the piezo driver.
package alert_pkg;

  typedef enum logic [1:0] {
    OFF,
    WARMUP,
    RUN
  } state_t;

  localparam int CNT_W = 4;

  localparam int          DEF_BATT_W       = 12;
  localparam int          DEF_DUTY_W       = 11;
  localparam logic [11:0] DEF_BATT_LOW_THR = 12'h800;
  localparam logic [11:0] DEF_BATT_HYST    = 12'h040;
  localparam logic [10:0] DEF_SPD_THR      = 11'd1536;
  localparam logic [10:0] DEF_SPD_HYST     = 11'd64;
  localparam int          DEF_PERSIST      = 8;
  localparam int          DEF_WARM_CYC     = 1024;

endpackage

// File: rtl/hyst_persist_filter.sv
// Threshold + hysteresis + N-consecutive-sample persistence filter for one
// alert flag. Thresholds are W+1 bits so a clear level above 2^W-1 never matches.
module hyst_persist_filter
  import alert_pkg::*;
#(
  parameter int         W       = 12,
  parameter logic [W:0] SET_THR = '0,
  parameter logic [W:0] CLR_THR = '0,
  parameter bit         ABOVE   = 1'b0,
  parameter int         PERSIST = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         vld,
  input  logic [W-1:0] sample,
  output logic         flag
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERSIST - 1);

  logic [W:0]       sample_ext;
  logic             set_hit;
  logic             clr_hit;
  logic             qualify;
  logic [CNT_W-1:0] cnt;

  assign sample_ext = {1'b0, sample};
  assign set_hit    = ABOVE ? (sample_ext > SET_THR) : (sample_ext < SET_THR);
  assign clr_hit    = ABOVE ? (sample_ext <= CLR_THR) : (sample_ext >= CLR_THR);
  // While set, only the clear condition counts; band samples restart the run.
  assign qualify    = flag ? clr_hit : set_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (vld) begin
      if (!qualify) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt  <= '0;
        flag <= ~flag;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alert_qualifier.sv
// Power-up sequencer plus battery and over-speed qualification; drives the
// norm_mode, ovr_spd and batt_low inputs of the piezo driver.
module alert_qualifier
  import alert_pkg::*;
#(
  parameter int                BATT_W       = DEF_BATT_W,
  parameter int                DUTY_W       = DEF_DUTY_W,
  parameter logic [BATT_W-1:0] BATT_LOW_THR = BATT_W'(DEF_BATT_LOW_THR),
  parameter logic [BATT_W-1:0] BATT_HYST    = BATT_W'(DEF_BATT_HYST),
  parameter logic [DUTY_W-1:0] SPD_THR      = DUTY_W'(DEF_SPD_THR),
  parameter logic [DUTY_W-1:0] SPD_HYST     = DUTY_W'(DEF_SPD_HYST),
  parameter int                PERSIST      = DEF_PERSIST,
  parameter int                WARM_CYC     = DEF_WARM_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwr_up,
  input  logic              batt_vld,
  input  logic [BATT_W-1:0] batt,
  input  logic              duty_vld,
  input  logic [DUTY_W-1:0] duty_mag,
  output logic              norm_mode,
  output logic              ovr_spd,
  output logic              batt_low
);

  localparam logic [BATT_W:0] BATT_SET  = {1'b0, BATT_LOW_THR};
  localparam logic [BATT_W:0] BATT_CLR  = {1'b0, BATT_LOW_THR} + {1'b0, BATT_HYST};
  localparam logic [DUTY_W:0] SPD_SET   = {1'b0, SPD_THR};
  localparam logic [DUTY_W:0] SPD_CLR   = {1'b0, SPD_THR - SPD_HYST};
  localparam int              WARM_W    = (WARM_CYC > 1) ? $clog2(WARM_CYC) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM_CYC - 1);

  state_t            state;
  state_t            next_state;
  logic [WARM_W-1:0] warm_cnt;
  logic [WARM_W-1:0] warm_next;
  logic              filter_clr;

  always_comb begin
    next_state = state;
    warm_next  = warm_cnt;
    if (!pwr_up) begin
      next_state = OFF;
      warm_next  = '0;
    end else begin
      case (state)
        OFF: begin
          next_state = WARMUP;
          warm_next  = '0;
        end
        WARMUP: begin
          if (warm_cnt == WARM_LAST) begin
            next_state = RUN;
            warm_next  = '0;
          end else begin
            warm_next = warm_cnt + 1'b1;
          end
        end
        RUN: begin
          next_state = RUN;
        end
        default: begin
          next_state = OFF;
          warm_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OFF;
      warm_cnt  <= '0;
      norm_mode <= 1'b0;
    end else begin
      state     <= next_state;
      warm_cnt  <= warm_next;
      norm_mode <= (next_state == RUN);
    end
  end

  // pwr_up dropping clears the filters on the same edge, beating any sample.
  assign filter_clr = (state != RUN) || !pwr_up;

  hyst_persist_filter #(
    .W       (BATT_W),
    .SET_THR (BATT_SET),
    .CLR_THR (BATT_CLR),
    .ABOVE   (1'b0),
    .PERSIST (PERSIST)
  ) u_batt_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (filter_clr),
    .vld    (batt_vld),
    .sample (batt),
    .flag   (batt_low)
  );

  hyst_persist_filter #(
    .W       (DUTY_W),
    .SET_THR (SPD_SET),
    .CLR_THR (SPD_CLR),
    .ABOVE   (1'b1),
    .PERSIST (PERSIST)
  ) u_spd_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (filter_clr),
    .vld    (duty_vld),
    .sample (duty_mag),
    .flag   (ovr_spd)
  );

endmodule

// File: tb/tb_alert_qualifier.sv
// Scoreboard bench for alert_qualifier with PERSIST=4 and WARM_CYC=16; outputs
// are compared as {norm_mode, ovr_spd, batt_low}.
module tb_alert_qualifier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pwr_up;
  logic        batt_vld;
  logic [11:0] batt;
  logic        duty_vld;
  logic [10:0] duty_mag;
  logic        norm_mode;
  logic        ovr_spd;
  logic        batt_low;

  typedef struct {
    logic [2:0] exp;
    string      name;
  } sb_item_t;

  sb_item_t sb[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alert_qualifier #(
    .PERSIST  (4),
    .WARM_CYC (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwr_up    (pwr_up),
    .batt_vld  (batt_vld),
    .batt      (batt),
    .duty_vld  (duty_vld),
    .duty_mag  (duty_mag),
    .norm_mode (norm_mode),
    .ovr_spd   (ovr_spd),
    .batt_low  (batt_low)
  );

  task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual={norm,ovr,batt}=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs at a negedge and queues the outputs expected after the next posedge.
  task automatic applyStimulus(input logic pwr, input logic bv, input logic [11:0] b,
                               input logic dv, input logic [10:0] d,
                               input logic [2:0] exp, input string name);
    pwr_up   = pwr;
    batt_vld = bv;
    batt     = b;
    duty_vld = dv;
    duty_mag = d;
    sb.push_back('{exp: exp, name: name});
    @(negedge clk);
  endtask

  task automatic runWarmup(input string name);
    for (int i = 1; i <= 16; i++)
      applyStimulus(1'b1, 1'b1, 12'h100, 1'b1, 11'd1600, 3'b000, name);
    applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 11'd0, 3'b100, {name, "_done"});
  endtask

  initial begin : monitor
    sb_item_t item;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        item = sb.pop_front();
        checkOutput(item.name, {norm_mode, ovr_spd, batt_low}, item.exp);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin : driver
    rst_n    = 1'b0;
    pwr_up   = 1'b0;
    batt_vld = 1'b0;
    batt     = '0;
    duty_vld = 1'b0;
    duty_mag = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", {norm_mode, ovr_spd, batt_low}, 3'b000);
    rst_n = 1'b1;

    runWarmup("warmup");

    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 12'h7FF, 1'b0, 11'd0, 3'b100, "batt_run1");
    applyStimulus(1'b1, 1'b1, 12'h900, 1'b0, 11'd0, 3'b100, "batt_break");
    applyStimulus(1'b1, 1'b1, 12'h7FF, 1'b0, 11'd0, 3'b100, "batt_run2");
    applyStimulus(1'b1, 1'b1, 12'h7FF, 1'b0, 11'd0, 3'b100, "batt_run2");
    applyStimulus(1'b1, 1'b0, 12'h7FF, 1'b0, 11'd0, 3'b100, "batt_idle");
    applyStimulus(1'b1, 1'b1, 12'h7FF, 1'b0, 11'd0, 3'b100, "batt_run2");
    applyStimulus(1'b1, 1'b1, 12'h7FF, 1'b0, 11'd0, 3'b101, "batt_set");

    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 1'b1, 12'h820, 1'b0, 11'd0, 3'b101, "batt_band");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 12'h840, 1'b0, 11'd0, (i == 3) ? 3'b100 : 3'b101, "batt_clear");

    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b0, 12'h000, 1'b1, 11'd1537, (i == 3) ? 3'b110 : 3'b100, "spd_set");
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 1'b0, 12'h000, 1'b1, 11'd1500, 3'b110, "spd_band");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b0, 12'h000, 1'b1, 11'd1472, (i == 3) ? 3'b100 : 3'b110, "spd_clear");

    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 12'h700, 1'b1, 11'd1600, (i == 3) ? 3'b111 : 3'b100, "both_set");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 12'h900, 1'b1, 11'd1000, (i == 3) ? 3'b100 : 3'b111, "both_clear");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 12'h700, 1'b1, 11'd1600, 3'b100, "both_pre_drop");
    applyStimulus(1'b0, 1'b1, 12'h700, 1'b1, 11'd1600, 3'b000, "pwr_drop");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 11'd0, 3'b000, "off_idle");

    runWarmup("rewarm");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b0, 12'h000, 1'b1, 11'd1600, (i == 3) ? 3'b110 : 3'b100, "spd_set2");
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 1'b0, 12'h000, 1'b1, 11'd1000, 3'b110, "spd_midcount");
    applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 11'd0, 3'b110, "spd_hold");

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", {norm_mode, ovr_spd, batt_low}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    runWarmup("post_reset_warmup");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b0, 12'h000, 1'b1, 11'd1600, (i == 3) ? 3'b110 : 3'b100, "spd_set3");

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
